// File: rtl/serneg_pkg.sv
// Shared types and constants for the serial two's-complement negator sequencer.
// Holds the FSM state enum, the default word width and a reference negation function.
package serneg_pkg;

  localparam int SERNEG_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } serneg_state_t;

  function automatic logic [SERNEG_WIDTH-1:0] serneg_ref(input logic [SERNEG_WIDTH-1:0] word);
    return ~word + SERNEG_WIDTH'(1);
  endfunction

endpackage

// File: rtl/serneg_bit.sv
// Single-bit serial negator cell: passes bits through until the first 1 has gone by,
// then inverts every later bit. clr restarts the cell; en gates the flag update.
module serneg_bit (
  input  logic t_clock,
  input  logic r,
  input  logic clr,
  input  logic en,
  input  logic i,
  output logic y
);

  logic r_seen_one;

  always_ff @(posedge t_clock or posedge r) begin
    if (r) begin
      r_seen_one <= 1'b0;
    end else if (clr) begin
      r_seen_one <= 1'b0;
    end else if (en) begin
      r_seen_one <= r_seen_one | i;
    end
  end

  assign y = r_seen_one ? ~i : i;

endmodule

// File: rtl/serneg_seq.sv
// Parallel-in/parallel-out sequencer around serneg_bit: accept, shift LSB-first for
// WIDTH cycles, present result. Define SERNEG_OVF_EN to add the ovf output.
module serneg_seq
  import serneg_pkg::*;
#(
  parameter  int WIDTH = SERNEG_WIDTH,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             t_clock,
  input  logic             r,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             ser_y
`ifdef SERNEG_OVF_EN
  ,
  output logic             ovf
`endif
);

  serneg_state_t    r_state;
  serneg_state_t    w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_en;
  logic             w_last;
  logic             w_bit;
  logic             w_y;

  assign w_bit  = r_shift[0];
  assign w_last = (r_state == SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

  serneg_bit u_cell (
    .t_clock (t_clock),
    .r       (r),
    .clr     (w_accept),
    .en      (w_en),
    .i       (w_bit),
    .y       (w_y)
  );

  always_ff @(posedge t_clock or posedge r) begin
    if (r) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_en         = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        w_en = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Result fills from the top so that after WIDTH shifts bit 0 holds the first cell output.
  always_ff @(posedge t_clock or posedge r) begin
    if (r) begin
      r_shift  <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_shift <= in_data;
      r_cnt   <= '0;
    end else if (w_en) begin
      r_shift  <= r_shift >> 1;
      r_result <= {w_y, r_result[WIDTH-1:1]};
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  assign out_data = r_result;
  assign ser_y    = w_en & w_y;

`ifdef SERNEG_OVF_EN
  logic r_ovf;

  // For an input 1, y equals ~seen_one, so (bit & y) marks a lone final 1.
  always_ff @(posedge t_clock or posedge r) begin
    if (r) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= w_bit & w_y;
    end else if (out_valid && out_ready) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serneg_seq.sv
// Self-checking bench for serneg_seq (WIDTH=8): directed scenarios plus a
// scoreboard-driven back-to-back run with random out_ready.
module tb_serneg_seq;
  import serneg_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         r = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;
  logic         ser_y;
`ifdef SERNEG_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb_q[$];

  always #5 clk = ~clk;

  serneg_seq #(.WIDTH(W)) dut (
    .t_clock   (clk),
    .r         (r),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .ser_y     (ser_y)
`ifdef SERNEG_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word while idle; expected result is queued at the accept edge.
  task automatic accept(input logic [W-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sb_q.push_back(serneg_ref(d));
    $display("accept in=%02h exp=%02h", d, serneg_ref(d));
  endtask

  // Cycles from the accept edge until out_valid; -1 if it never rises.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%02h exp=00", out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (ser_y !== 1'b0) begin errors++; $display("FAIL reset_ser_y got=%b exp=0", ser_y); end
    $display("reset in_ready=%b out_valid=%b out_data=%02h", in_ready, out_valid, out_data);
  endtask

  task automatic test_basic();
    int lat;
    logic [W-1:0] exp;
    out_ready = 1'b1;
    accept(8'h01);
    wait_valid(lat);
    exp = sb_q.pop_front();
    checks += 3;
    if (lat !== W) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W); end
    if (out_data !== exp) begin errors++; $display("FAIL basic_data got=%02h exp=%02h", out_data, exp); end
    if (exp !== 8'hFF) begin errors++; $display("FAIL basic_ref got=%02h exp=ff", exp); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got=%b exp=0", out_valid); end
    $display("basic out=%02h lat=%0d", exp, lat);
  endtask

  task automatic test_ser_y();
    logic [W-1:0] seq;
    logic [W-1:0] exp;
    out_ready = 1'b1;
    accept(8'h06);
    for (int k = 0; k < W; k++) begin
      seq[k] = ser_y;
      tick();
    end
    exp = sb_q.pop_front();
    checks += 3;
    if (seq !== 8'hFA) begin errors++; $display("FAIL ser_y_seq got=%02h exp=fa", seq); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL ser_y_valid got=%b exp=1", out_valid); end
    if (out_data !== exp) begin errors++; $display("FAIL ser_y_data got=%02h exp=%02h", out_data, exp); end
    tick();
    checks++;
    if (ser_y !== 1'b0) begin errors++; $display("FAIL ser_y_idle got=%b exp=0", ser_y); end
    $display("ser_y seq=%02h out=%02h", seq, exp);
  endtask

  task automatic test_edges();
    logic [W-1:0] vals[2];
    int lat;
    logic [W-1:0] exp;
    vals[0] = 8'h00;
    vals[1] = 8'h80;
    out_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      accept(vals[n]);
      wait_valid(lat);
      exp = sb_q.pop_front();
      checks += 2;
      if (lat !== W) begin errors++; $display("FAIL edge_latency in=%02h got=%0d exp=%0d", vals[n], lat, W); end
      if (out_data !== vals[n]) begin errors++; $display("FAIL edge_data in=%02h got=%02h exp=%02h", vals[n], out_data, vals[n]); end
`ifdef SERNEG_OVF_EN
      checks++;
      if (ovf !== (n == 1)) begin errors++; $display("FAIL edge_ovf in=%02h got=%b exp=%b", vals[n], ovf, (n == 1)); end
`endif
      $display("edge in=%02h out=%02h exp=%02h", vals[n], out_data, exp);
      tick();
`ifdef SERNEG_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL edge_ovf_clear got=%b exp=0", ovf); end
`endif
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [W-1:0] exp;
    out_ready = 1'b0;
    accept(8'h06);
    wait_valid(lat);
    exp = sb_q.pop_front();
    checks++;
    if (lat !== W) begin errors++; $display("FAIL stall_latency got=%0d exp=%0d", lat, W); end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", k, out_valid); end
      if (out_data !== exp) begin errors++; $display("FAIL stall_data cyc=%0d got=%02h exp=%02h", k, out_data, exp); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
      $display("stall cyc=%0d out_valid=%b out_data=%02h", k, out_valid, out_data);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL stall_no_accept got=%b exp=0", busy); end
  endtask

  task automatic test_async_reset();
    int lat;
    logic [W-1:0] exp;
    out_ready = 1'b1;
    in_data   = 8'h5B;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2;
    r = 1'b1;
    #1;
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL areset_out_data got=%02h exp=00", out_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
    if (ser_y !== 1'b0) begin errors++; $display("FAIL areset_ser_y got=%b exp=0", ser_y); end
    $display("areset busy=%b out_data=%02h", busy, out_data);
    r = 1'b0;
    tick();
    accept(8'h01);
    wait_valid(lat);
    exp = sb_q.pop_front();
    checks += 2;
    if (lat !== W) begin errors++; $display("FAIL areset_next_latency got=%0d exp=%0d", lat, W); end
    if (out_data !== 8'hFF) begin errors++; $display("FAIL areset_next_data got=%02h exp=ff", out_data); end
    $display("areset next out=%02h exp=%02h", out_data, exp);
    tick();
  endtask

  task automatic test_back_to_back();
    int got = 0;
    logic [W-1:0] exp;
    fork
      begin : driver
        logic acc;
        int guard;
        for (int n = 0; n < 16; n++) begin
          in_data  = 8'($urandom);
          in_valid = 1'b1;
          guard    = 0;
          do begin
            acc = in_ready;
            tick();
            guard++;
          end while (!acc && guard < 200);
          if (acc) sb_q.push_back(serneg_ref(in_data));
        end
        in_valid = 1'b0;
      end
      begin : monitor
        for (int c = 0; c < 3000 && got < 16; c++) begin
          out_ready = 1'($urandom);
          if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL b2b_extra got=%02h exp=none", out_data);
            end else begin
              exp = sb_q.pop_front();
              if (out_data !== exp) begin errors++; $display("FAIL b2b_data n=%0d got=%02h exp=%02h", got, out_data, exp); end
              $display("b2b n=%0d out=%02h exp=%02h", got, out_data, exp);
            end
            got++;
          end
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b0;
    checks += 2;
    if (got !== 16) begin errors++; $display("FAIL b2b_count got=%0d exp=16", got); end
    if (sb_q.size() !== 0) begin errors++; $display("FAIL b2b_leftover got=%0d exp=0", sb_q.size()); end
  endtask

  initial begin
    #12;
    test_reset();
    r = 1'b0;
    tick();
    test_basic();
    test_ser_y();
    test_edges();
    test_stall();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serneg_seq.md
Name: serneg_seq

Overview:
- Sequencer wrapping a bit-serial two's-complement negator cell.
- Accepts a parallel word over a valid/ready handshake and clears the serial cell.
- Streams the word LSB-first through the cell for WIDTH cycles, reassembles the serial result into a parallel word, and presents it on an output handshake.
- Sits between parallel producers/consumers and the serial negation datapath; it is the only block that drives the cell's clear and shift-enable.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, width of the internal bit counter; derived, not overridden.

Ports:
- t_clock  input  1  system clock; all state updates on the rising edge.
- r  input  1  reset; asynchronous, active-high.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word; high only in IDLE.
- in_data  input  WIDTH  word to negate, two's complement.
- out_valid  output  1  out_data holds a completed result; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  negated word, -in_data mod 2^WIDTH.
- busy  output  1  high in SHIFT or DONE.
- ser_y  output  1  serial cell output bit this cycle; debug tap, 0 outside SHIFT.

Behaviour:
- Reset (r=1, asynchronous):
  - state=IDLE; shift, result and counter registers cleared.
  - Cell "seen-one" flag cleared.
  - in_ready=1, out_valid=0, out_data=0, busy=0, ser_y=0.
  - Applies immediately, including mid-SHIFT or in DONE. Any word in flight is discarded with no partial output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: load in_data into the shift register, clear the counter and the cell flag, go to SHIFT.
- SHIFT (one bit per cycle, WIDTH cycles exactly):
  - Current bit b = shift_reg[0].
  - Cell output y = seen_one ? ~b : b.
  - seen_one <= seen_one | b.
  - shift_reg >>= 1.
  - result <= {y, result[WIDTH-1:1]}.
  - counter += 1.
  - On the edge where the counter reaches WIDTH-1: the final bit is shifted and the state goes to DONE.
  - in_valid is ignored and in_ready=0.
- Latency: with the accept edge counted as edge 0, out_valid rises after edge WIDTH. For WIDTH=8 the result is valid 8 cycles after the accept cycle.
- DONE:
  - out_valid=1; out_data stable until the handshake.
  - On an edge with out_ready=1, go to IDLE.
  - No accept in the same cycle, so back-to-back words cost WIDTH+2 cycles each.
  - out_ready held low stalls indefinitely with no loss of data.
- out_data is driven from the result register and holds its last value in IDLE (0 after reset).
- Arithmetic is modulo 2^WIDTH:
  - 0 maps to 0.
  - The most-negative value (1 followed by WIDTH-1 zeros) maps to itself.
- Simultaneous events: r dominates everything. in_valid and out_ready never interact, because no state has both ready signals high.

Optional Feature:
- Macro SERNEG_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - ovf is set in DONE when the input word was the most-negative value: the last shifted bit was 1 and seen_one was 0 before it.
  - ovf is valid with out_valid, cleared on reset and on leaving DONE.
- Undefined: no ovf port and no extra logic; behaviour is otherwise identical.

Decomposition:
- Package serneg_pkg:
  - State enum serneg_state_t {IDLE, SHIFT, DONE}.
  - Default WIDTH constant.
  - Function serneg_ref(word) returning (~word+1) for scoreboards.
- Sub-module serneg_bit: the single-bit serial cell.
  - Ports t_clock, r, clr, en, i, y.
  - Owns the seen_one flop; clr is synchronous and en gates the update.
  - serneg_seq instantiates one serneg_bit and owns the FSM, counter and shift/result registers.

Test Plan:
- WIDTH=8, in_data=0x01 with out_ready=1 -> out_data=0xFF, out_valid rises 8 cycles after accept and lasts 1 cycle.
- in_data=0x06 -> out_data=0xFA; ser_y sequence LSB-first = 0,1,0,1,1,1,1,1.
- in_data=0x00 -> out_data=0x00. in_data=0x80 -> out_data=0x80, and ovf=1 when SERNEG_OVF_EN is defined.
- out_ready=0 for 5 cycles in DONE -> out_valid and out_data=0xFA held; in_valid pulses during this time are ignored (in_ready=0).
- r pulsed asynchronously at SHIFT bit 3 -> outputs immediately at reset values. The next word 0x01 is then processed correctly -> 0xFF.
- 16 random words back-to-back with in_valid held high and random out_ready -> every result equals serneg_ref, in order, with none dropped or duplicated.
